// File: rtl/ma_pkg.sv
// Shared definitions for the memory-access stage: FSM states, default widths
// and the load/store/none decode used when an instruction is accepted.
package ma_pkg;

  localparam int MA_DW = 32;
  localparam int MA_RW = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM_WAIT,
    ST_WB_HOLD
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_LOAD,
    OP_STORE
  } op_e;

  // A load takes precedence when both read and write are flagged.
  function automatic op_e decode_op(input logic mem_read, input logic mem_write);
    op_e op;
    op = OP_NONE;
    if (mem_read) op = OP_LOAD;
    else if (mem_write) op = OP_STORE;
    return op;
  endfunction

endpackage

// File: rtl/ma_timeout_ctr.sv
// Clearable up-counter that flags the cycle on which an outstanding memory
// request has been waiting TIMEOUT cycles.
module ma_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // r_cnt holds the number of request cycles already spent without an ack,
  // so the current enabled cycle is the TIMEOUT-th one when r_cnt == LAST.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: one optional load/store per instruction over a
// request/ack port, result handed to write-back with a valid/ready handshake.
module mem_access_unit
  import ma_pkg::*;
#(
  parameter int DW      = MA_DW,
  parameter int RW      = MA_RW,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] alu_result,
  input  logic [DW-1:0] new_rs1,
  input  logic [RW-1:0] rd,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic          reg_write,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [DW-1:0] wb_data,
  output logic [RW-1:0] wb_rd,
  output logic          wb_we,
  output logic          misalign_err,
  output logic          timeout_err
);

  state_e        r_state, w_state_nxt;
  logic          r_is_load, w_is_load_nxt;
  logic          r_reg_write, w_reg_write_nxt;
  logic          r_mem_req, w_mem_req_nxt;
  logic          r_mem_we, w_mem_we_nxt;
  logic [DW-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic          r_wb_valid, w_wb_valid_nxt;
  logic [DW-1:0] r_wb_data, w_wb_data_nxt;
  logic [RW-1:0] r_wb_rd, w_wb_rd_nxt;
  logic          r_wb_we, w_wb_we_nxt;
  logic          r_misalign, w_misalign_nxt;
  logic          r_timeout, w_timeout_nxt;

  op_e  w_op;
  logic w_ctr_clr, w_ctr_en, w_expired;

  assign w_op     = decode_op(mem_read, mem_write);
  assign w_ctr_en = (r_state == ST_MEM_WAIT) && !mem_ack;

  ma_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_ctr_clr),
    .i_en     (w_ctr_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_is_load   <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_data   <= '0;
      r_wb_rd     <= '0;
      r_wb_we     <= 1'b0;
      r_misalign  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_is_load   <= w_is_load_nxt;
      r_reg_write <= w_reg_write_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_wb_valid  <= w_wb_valid_nxt;
      r_wb_data   <= w_wb_data_nxt;
      r_wb_rd     <= w_wb_rd_nxt;
      r_wb_we     <= w_wb_we_nxt;
      r_misalign  <= w_misalign_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_is_load_nxt   = r_is_load;
    w_reg_write_nxt = r_reg_write;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_wb_valid_nxt  = r_wb_valid;
    w_wb_data_nxt   = r_wb_data;
    w_wb_rd_nxt     = r_wb_rd;
    w_wb_we_nxt     = r_wb_we;
    w_misalign_nxt  = 1'b0;
    w_timeout_nxt   = 1'b0;
    w_ctr_clr       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_wb_rd_nxt     = rd;
          w_wb_data_nxt   = alu_result;
          w_reg_write_nxt = reg_write;
          w_is_load_nxt   = (w_op == OP_LOAD);
          if (w_op == OP_NONE) begin
            w_wb_we_nxt    = reg_write;
            w_wb_valid_nxt = 1'b1;
            w_state_nxt    = ST_WB_HOLD;
          end else if (alu_result[1:0] != 2'b00) begin
            w_wb_we_nxt    = 1'b0;
            w_wb_valid_nxt = 1'b1;
            w_misalign_nxt = 1'b1;
            w_state_nxt    = ST_WB_HOLD;
          end else begin
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = (w_op == OP_STORE);
            w_mem_addr_nxt  = alu_result;
            w_mem_wdata_nxt = new_rs1;
            w_wb_we_nxt     = 1'b0;
            w_ctr_clr       = 1'b1;
            w_state_nxt     = ST_MEM_WAIT;
          end
        end
      end

      // An ack on the expiry cycle still completes normally.
      ST_MEM_WAIT: begin
        if (mem_ack || w_expired) begin
          w_mem_req_nxt  = 1'b0;
          w_mem_we_nxt   = 1'b0;
          w_wb_valid_nxt = 1'b1;
          w_wb_we_nxt    = 1'b0;
          w_state_nxt    = ST_WB_HOLD;
          if (!mem_ack) begin
            w_timeout_nxt = 1'b1;
          end else if (r_is_load) begin
            w_wb_data_nxt = mem_rdata;
            w_wb_we_nxt   = r_reg_write;
          end
        end
      end

      ST_WB_HOLD: begin
        if (wb_ready) begin
          w_wb_valid_nxt = 1'b0;
          w_wb_we_nxt    = 1'b0;
          w_state_nxt    = ST_IDLE;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign in_ready     = (r_state == ST_IDLE);
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign wb_valid     = r_wb_valid;
  assign wb_data      = r_wb_data;
  assign wb_rd        = r_wb_rd;
  assign wb_we        = r_wb_we;
  assign misalign_err = r_misalign;
  assign timeout_err  = r_timeout;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: per-instruction timelines computed from the
// stage's rules, checked cycle by cycle, plus literal checks on directed cases.
module tb_mem_access_unit;

  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] new_rs1;
  logic [RW-1:0] rd;
  logic          mem_read;
  logic          mem_write;
  logic          reg_write;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          wb_valid;
  logic          wb_ready;
  logic [DW-1:0] wb_data;
  logic [RW-1:0] wb_rd;
  logic          wb_we;
  logic          misalign_err;
  logic          timeout_err;

  mem_access_unit #(
    .DW(DW), .RW(RW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .new_rs1(new_rs1), .rd(rd),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_we(wb_we), .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          in_ready;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          wb_valid;
    logic [DW-1:0] wb_data;
    logic [RW-1:0] wb_rd;
    logic          wb_we;
    logic          mis;
    logic          to;
    bit            chk_wbd;
  } exp_t;

  exp_t expq[$];
  exp_t ce;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cycles = 0, wbv_cycles = 0, mis_pulses = 0, to_pulses = 0;
  logic [DW-1:0] last_wb_data;
  logic [RW-1:0] last_wb_rd;
  logic          last_wb_we;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  // Single compare process: one expected record per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      ce = expq.pop_front();
      chk("in_ready", 32'(in_ready), 32'(ce.in_ready));
      chk("mem_req", 32'(mem_req), 32'(ce.mem_req));
      chk("mem_we", 32'(mem_we), 32'(ce.mem_we));
      chk("wb_valid", 32'(wb_valid), 32'(ce.wb_valid));
      chk("wb_we", 32'(wb_we), 32'(ce.wb_we));
      chk("misalign_err", 32'(misalign_err), 32'(ce.mis));
      chk("timeout_err", 32'(timeout_err), 32'(ce.to));
      if (ce.mem_req) begin
        chk("mem_addr", mem_addr, ce.mem_addr);
        chk("mem_wdata", mem_wdata, ce.mem_wdata);
      end
      if (ce.wb_valid) begin
        chk("wb_rd", 32'(wb_rd), 32'(ce.wb_rd));
        if (ce.chk_wbd) chk("wb_data", wb_data, ce.wb_data);
      end
      cyc++;
    end
    if (mem_req === 1'b1) req_cycles++;
    if (misalign_err === 1'b1) mis_pulses++;
    if (timeout_err === 1'b1) to_pulses++;
    if (wb_valid === 1'b1) begin
      wbv_cycles++;
      last_wb_data = wb_data;
      last_wb_rd   = wb_rd;
      last_wb_we   = wb_we;
    end
  end

  function automatic exp_t idle_exp();
    exp_t e;
    e = '{default: '0};
    e.in_ready = 1'b1;
    return e;
  endfunction

  task automatic step(input exp_t e);
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    alu_result = $urandom;
    new_rs1    = $urandom;
    rd         = RW'($urandom);
    mem_read   = 1'($urandom);
    mem_write  = 1'($urandom);
    reg_write  = 1'($urandom);
    mem_rdata  = $urandom;
  endtask

  task automatic clr_counts();
    req_cycles = 0; wbv_cycles = 0; mis_pulses = 0; to_pulses = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      junk();
      mem_ack  = 1'($urandom);
      wb_ready = 1'($urandom);
      step(idle_exp());
    end
    mem_ack = 1'b0;
  endtask

  // Drives one instruction from acceptance to write-back handshake and
  // queues the outputs the stage must show on every cycle of it.
  task automatic run_instr(input bit mr, input bit mw, input logic [DW-1:0] addr,
                           input logic [DW-1:0] sd, input logic [RW-1:0] rdi,
                           input bit rw, input int ack_lat, input logic [DW-1:0] rdata,
                           input int ready_lat);
    exp_t e;
    bit is_mem, is_load, mis, acked, terr, we;
    int lat;
    logic [DW-1:0] wbd;
    is_mem  = mr || mw;
    is_load = mr;
    mis     = is_mem && (addr[1:0] != 2'b00);
    acked   = 1'b0;
    terr    = 1'b0;
    in_valid = 1'b1; alu_result = addr; new_rs1 = sd; rd = rdi;
    mem_read = mr; mem_write = mw; reg_write = rw;
    mem_ack = 1'($urandom); wb_ready = 1'($urandom); mem_rdata = $urandom;
    step(idle_exp());
    in_valid = 1'b0;
    junk();
    wbd = addr;
    we  = !is_mem && rw;
    if (is_mem && !mis) begin
      acked = (ack_lat <= TMO);
      lat   = acked ? ack_lat : TMO;
      for (int c = 1; c <= lat; c++) begin
        e = '{default: '0};
        e.mem_req   = 1'b1;
        e.mem_we    = !is_load;
        e.mem_addr  = addr;
        e.mem_wdata = sd;
        mem_ack   = acked && (c == lat);
        mem_rdata = (acked && c == lat) ? rdata : DW'($urandom);
        wb_ready  = 1'($urandom);
        step(e);
        junk();
      end
      terr = !acked;
      if (acked && is_load) wbd = rdata;
      we = acked && is_load && rw;
    end
    mem_ack = 1'b0;
    for (int c = 0; c <= ready_lat; c++) begin
      e = '{default: '0};
      e.wb_valid = 1'b1;
      e.wb_data  = wbd;
      e.wb_rd    = rdi;
      e.wb_we    = we;
      e.mis      = (c == 0) && mis;
      e.to       = (c == 0) && terr;
      e.chk_wbd  = !is_mem || (is_load && acked);
      wb_ready   = (c == ready_lat);
      step(e);
      junk();
    end
    wb_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int k, alat, rlat, gap;
    bit mr, mw;
    logic [DW-1:0] a, sd;

    rst = 1'b1; in_valid = 1'b0; mem_ack = 1'b0; wb_ready = 1'b0;
    junk();
    @(posedge clk); #1;
    step(idle_exp());
    step(idle_exp());
    rst = 1'b0;
    idle(1);

    // ALU op
    clr_counts();
    run_instr(1'b0, 1'b0, 32'h1234, 32'h5555, 5'd7, 1'b1, 0, 32'h0, 0);
    chk("alu_lit_data", last_wb_data, 32'h1234);
    chk("alu_lit_rd", 32'(last_wb_rd), 32'd7);
    chk("alu_lit_we", 32'(last_wb_we), 32'd1);
    chk("alu_lit_req", 32'(req_cycles), 32'd0);
    chk("alu_lit_wbv", 32'(wbv_cycles), 32'd1);

    // Load with three-cycle latency
    clr_counts();
    run_instr(1'b1, 1'b0, 32'h100, 32'h0, 5'd9, 1'b1, 3, 32'hDEADBEEF, 0);
    chk("ld_lit_req", 32'(req_cycles), 32'd3);
    chk("ld_lit_data", last_wb_data, 32'hDEADBEEF);
    chk("ld_lit_we", 32'(last_wb_we), 32'd1);

    // Store with write-back back-pressure
    clr_counts();
    run_instr(1'b0, 1'b1, 32'h104, 32'hCAFE, 5'd2, 1'b1, 1, 32'h0, 4);
    chk("st_lit_wbv", 32'(wbv_cycles), 32'd5);
    chk("st_lit_we", 32'(last_wb_we), 32'd0);
    chk("st_lit_req", 32'(req_cycles), 32'd1);

    // Misaligned load
    clr_counts();
    run_instr(1'b1, 1'b0, 32'h102, 32'h0, 5'd4, 1'b1, 1, 32'h0, 0);
    chk("mis_lit_req", 32'(req_cycles), 32'd0);
    chk("mis_lit_pulse", 32'(mis_pulses), 32'd1);
    chk("mis_lit_we", 32'(last_wb_we), 32'd0);

    // Timeout, then ack on the last permitted cycle
    clr_counts();
    run_instr(1'b1, 1'b0, 32'h200, 32'h0, 5'd5, 1'b1, TMO + 1, 32'h0, 0);
    chk("to_lit_req", 32'(req_cycles), 32'd4);
    chk("to_lit_pulse", 32'(to_pulses), 32'd1);
    chk("to_lit_we", 32'(last_wb_we), 32'd0);
    clr_counts();
    run_instr(1'b1, 1'b0, 32'h204, 32'h0, 5'd6, 1'b1, TMO, 32'h0BADF00D, 0);
    chk("ack4_lit_req", 32'(req_cycles), 32'd4);
    chk("ack4_lit_pulse", 32'(to_pulses), 32'd0);
    chk("ack4_lit_data", last_wb_data, 32'h0BADF00D);

    // Reset in the middle of a request, then a late ack
    clr_counts();
    in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; alu_result = 32'h300;
    new_rs1 = 32'h77; rd = 5'd3; reg_write = 1'b1; mem_ack = 1'b0;
    step(idle_exp());
    in_valid = 1'b0;
    e = '{default: '0};
    e.mem_req = 1'b1; e.mem_addr = 32'h300; e.mem_wdata = 32'h77;
    step(e);
    step(e);
    rst = 1'b1;
    step(e);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678;
    step(idle_exp());
    mem_ack = 1'b0;
    step(idle_exp());
    step(idle_exp());
    chk("rst_lit_wbv", 32'(wbv_cycles), 32'd0);
    chk("rst_lit_req", 32'(req_cycles), 32'd3);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      k  = $urandom_range(0, 9);
      mr = ((k >= 3) && (k < 7)) || (k == 9);
      mw = (k >= 7);
      a  = $urandom;
      if ($urandom_range(0, 9) < 7) a[1:0] = 2'b00;
      sd   = $urandom;
      alat = $urandom_range(1, TMO + 2);
      rlat = $urandom_range(0, 3);
      gap  = $urandom_range(0, 2);
      run_instr(mr, mw, a, sd, RW'($urandom), 1'($urandom), alat, DW'($urandom), rlat);
      idle(gap);
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
